sdram_arbit: RTL and testbench

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_pkg.sv | 21 ++
 rtl/sdram_arbit.sv | 111 +++++++++++
 tb/tb_sdram_arbit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command codes and the arbiter state encoding.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_P_CHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_M_REG_SET = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_B_STOP    = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } arbit_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: hands the command/address pins to init, auto-refresh,
// write or read with fixed priority and drives the tri-state data bus.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int DQ_W   = 16,
  parameter int ADDR_W = 13
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_end,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq,
  output arbit_state_t      dbg_state
);

  arbit_state_t state, state_nxt;
  logic [3:0]   sel_cmd;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Every operation returns through ARBIT, which guarantees a NOP cycle
  // between back-to-back grants.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (init_end) state_nxt = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)    state_nxt = S_AREF;
        else if (wr_req) state_nxt = S_WRITE;
        else if (rd_req) state_nxt = S_READ;
      end
      S_AREF:  if (aref_end) state_nxt = S_ARBIT;
      S_WRITE: if (wr_end)   state_nxt = S_ARBIT;
      S_READ:  if (rd_end)   state_nxt = S_ARBIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sel_cmd    = init_cmd;
    sdram_ba   = init_ba;
    sdram_addr = init_addr;
    case (state)
      S_ARBIT: begin
        sel_cmd    = CMD_NOP;
        sdram_ba   = 2'b11;
        sdram_addr = '1;
      end
      S_AREF: begin
        sel_cmd    = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        sel_cmd    = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      S_READ: begin
        sel_cmd    = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sel_cmd;

  assign aref_en   = (state == S_AREF);
  assign wr_en     = (state == S_WRITE);
  assign rd_en     = (state == S_READ);
  assign sdram_cke = 1'b1;
  assign dbg_state = state;

  assign sdram_dq = wr_sdram_en ? wr_data : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios then random traffic, all checked
// against an owner-tracking reference model.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int DQ_W   = 16;
  localparam int ADDR_W = 13;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]        init_ba, aref_ba, wr_ba, rd_ba;
  logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic              init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic              wr_sdram_en;
  logic [DQ_W-1:0]   wr_data;
  logic              aref_en, wr_en, rd_en, sdram_cke;
  logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  wire  [DQ_W-1:0]   sdram_dq;
  arbit_state_t      dbg_state;

  int tests  = 0;
  int failed = 0;

  // Reference model: whether init has completed and who currently owns the bus.
  typedef enum int { OWN_NONE, OWN_AREF, OWN_WR, OWN_RD } owner_t;
  bit     m_ready;
  owner_t m_owner;

  // Weak pull makes an undriven bus read as all ones.
  for (genvar i = 0; i < DQ_W; i++) begin : g_pull
    pullup (sdram_dq[i]);
  end

  always #5 sys_clk = ~sys_clk;

  sdram_arbit #(.DQ_W(DQ_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .aref_end(aref_end),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_end(wr_end),
    .wr_sdram_en(wr_sdram_en), .wr_data(wr_data),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_end(rd_end),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq(sdram_dq), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_owner = OWN_NONE;
  endtask

  task automatic model_update();
    if (!sys_rst_n) begin
      model_reset();
    end else if (!m_ready) begin
      if (init_end) m_ready = 1'b1;
    end else if (m_owner != OWN_NONE) begin
      if ((m_owner == OWN_AREF && aref_end) || (m_owner == OWN_WR && wr_end) ||
          (m_owner == OWN_RD && rd_end))
        m_owner = OWN_NONE;
    end else if (aref_req) m_owner = OWN_AREF;
    else if (wr_req)       m_owner = OWN_WR;
    else if (rd_req)       m_owner = OWN_RD;
  endtask

  task automatic check_all();
    logic [3:0]        e_cmd;
    logic [1:0]        e_ba;
    logic [ADDR_W-1:0] e_addr;
    if (!m_ready) begin
      e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr;
    end else begin
      case (m_owner)
        OWN_AREF: begin e_cmd = aref_cmd; e_ba = aref_ba; e_addr = aref_addr; end
        OWN_WR:   begin e_cmd = wr_cmd;   e_ba = wr_ba;   e_addr = wr_addr;   end
        OWN_RD:   begin e_cmd = rd_cmd;   e_ba = rd_ba;   e_addr = rd_addr;   end
        default:  begin e_cmd = 4'b0111;  e_ba = 2'b11;   e_addr = {ADDR_W{1'b1}}; end
      endcase
    end
    check("aref_en", 32'(aref_en), 32'(m_ready && m_owner == OWN_AREF));
    check("wr_en",   32'(wr_en),   32'(m_ready && m_owner == OWN_WR));
    check("rd_en",   32'(rd_en),   32'(m_ready && m_owner == OWN_RD));
    check("cmd",  32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(e_cmd));
    check("ba",   32'(sdram_ba),   32'(e_ba));
    check("addr", 32'(sdram_addr), 32'(e_addr));
    check("cke",  32'(sdram_cke),  32'd1);
    check("dq",   32'(sdram_dq),   wr_sdram_en ? 32'(wr_data) : 32'hFFFF);
  endtask

  task automatic rand_buses();
    init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
    init_ba  = 2'($urandom); aref_ba  = 2'($urandom); wr_ba  = 2'($urandom); rd_ba  = 2'($urandom);
    init_addr = ADDR_W'($urandom); aref_addr = ADDR_W'($urandom);
    wr_addr   = ADDR_W'($urandom); rd_addr   = ADDR_W'($urandom);
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge sys_clk);
    model_update();
    @(negedge sys_clk);
    check_all();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = '0;
    wr_sdram_en = 1'b0;
    wr_data = '0;
    rand_buses();
    model_reset();
    repeat (3) tick();
    sys_rst_n = 1'b1;

    // Held in IDLE while init runs: pins follow the init sequencer.
    init_cmd = 4'b0010;
    for (int i = 0; i < 100; i++) begin
      rd_req = 1'($urandom);
      tick();
      check("idle_cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h2);
    end
    rd_req = 1'b0;
    init_end = 1'b1;
    tick();
    check("arbit_nop", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h7);
    init_end = 1'b0;
    tick();

    // Three simultaneous requests are served in priority order.
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    check("prio_aref", 32'({aref_en, wr_en, rd_en}), 32'b100);
    aref_req = 1'b0;
    tick();
    aref_end = 1'b1;
    tick();
    aref_end = 1'b0;
    check("gap_after_aref", 32'({aref_en, wr_en, rd_en}), 32'b000);
    tick();
    check("prio_wr", 32'({aref_en, wr_en, rd_en}), 32'b010);
    wr_req = 1'b0;

    // Data bus drive and release during the write.
    wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
    #1 check("dq_drive", 32'(sdram_dq), 32'hA5A5);
    tick();
    wr_sdram_en = 1'b0;
    #1 check("dq_release", 32'(sdram_dq), 32'hFFFF);

    // Foreign end strobes leave the write in place.
    aref_end = 1'b1; rd_end = 1'b1;
    tick();
    aref_end = 1'b0; rd_end = 1'b0;
    check("wr_hold", 32'(wr_en), 32'd1);
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    tick();
    check("prio_rd", 32'({aref_en, wr_en, rd_en}), 32'b001);
    rd_req = 1'b0;

    // End and new request in the same cycle: one NOP before the new grant.
    rd_end = 1'b1; aref_req = 1'b1;
    tick();
    rd_end = 1'b0;
    check("end_then_nop", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h7);
    tick();
    check("aref_after_nop", 32'(aref_en), 32'd1);
    aref_req = 1'b0;
    aref_end = 1'b1;
    tick();
    aref_end = 1'b0;

    // Reset in the middle of a read drops the grant at once.
    rd_req = 1'b1;
    tick();
    tick();
    check("rd_before_rst", 32'(rd_en), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check("rd_abort", 32'(rd_en), 32'd0);
    check_all();
    tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("no_grant_uninit", 32'({aref_en, wr_en, rd_en}), 32'b000);
    rd_req = 1'b0;

    // Random traffic; requesters hold their request until granted.
    for (int i = 0; i < 3000; i++) begin
      rand_buses();
      if (aref_en) aref_req = 1'b0;
      else if (!aref_req) aref_req = ($urandom_range(0, 15) == 0);
      if (wr_en) wr_req = 1'b0;
      else if (!wr_req) wr_req = ($urandom_range(0, 5) == 0);
      if (rd_en) rd_req = 1'b0;
      else if (!rd_req) rd_req = ($urandom_range(0, 5) == 0);
      aref_end    = ($urandom_range(0, 3) == 0);
      wr_end      = ($urandom_range(0, 3) == 0);
      rd_end      = ($urandom_range(0, 3) == 0);
      init_end    = ($urandom_range(0, 7) == 0);
      wr_sdram_en = 1'($urandom);
      wr_data     = DQ_W'($urandom);
      sys_rst_n   = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
